// File: rtl/mio_bus_ctrl.sv
// CPU bus controller: decodes each CPU transfer to synchronous RAM, the I/O page
// (LED, switches, timer) or unmapped space, and returns data with a one-cycle
// ready_o strobe. It also hosts a 32-bit compare timer that raises Ireq.
module mio_bus_ctrl #(
    parameter int unsigned RAM_AW  = 10,
    parameter logic [31:0] IO_BASE = 32'hF000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              breq_i,
    input  logic              mem_w,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              ready_o,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_i,
    output logic [15:0]       led_o,
    output logic              Ireq,
    input  logic              Iack
);

    typedef enum logic [1:0] {IDLE, ACCESS, RAM_WAIT, RESP} state_t;

    localparam logic [31:0] ADDR_LED = IO_BASE;
    localparam logic [31:0] ADDR_SW  = IO_BASE + 32'h4;
    localparam logic [31:0] ADDR_CMP = IO_BASE + 32'h8;
    localparam logic [31:0] ADDR_CNT = IO_BASE + 32'hC;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_we;
    logic [31:0] r_data_o;
    logic [15:0] r_led;
    logic [31:0] r_cmp;
    logic [31:0] r_cnt;
    logic        r_pend;

    logic        w_is_ram;
    logic        w_sel_led;
    logic        w_sel_sw;
    logic        w_sel_cmp;
    logic        w_sel_cnt;
    logic        w_io_wr;
    logic        w_wr_cnt;
    logic        w_match;
    logic [31:0] w_rd_data;

    // Target decode works on the latched address; RAM takes priority over the I/O page.
    assign w_is_ram  = (r_addr[31:RAM_AW+2] == '0);
    assign w_sel_led = (r_addr == ADDR_LED);
    assign w_sel_sw  = (r_addr == ADDR_SW);
    assign w_sel_cmp = (r_addr == ADDR_CMP);
    assign w_sel_cnt = (r_addr == ADDR_CNT);
    assign w_io_wr   = (r_state == ACCESS) && r_we && !w_is_ram;
    assign w_wr_cnt  = w_io_wr && w_sel_cnt;
    assign w_match   = (r_cmp != 32'h0) && (r_cnt == r_cmp);

    // I/O read mux; anything not decoded reads as zero.
    always_comb begin
        w_rd_data = 32'h0;
        if (w_sel_led) begin
            w_rd_data = {16'h0, r_led};
        end else if (w_sel_sw) begin
            w_rd_data = {16'h0, sw_i};
        end else if (w_sel_cmp) begin
            w_rd_data = r_cmp;
        end else if (w_sel_cnt) begin
            w_rd_data = r_cnt;
        end
    end

    // Transfer FSM: latch request, access target, capture read data, strobe ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_addr   <= 32'h0;
            r_data   <= 32'h0;
            r_we     <= 1'b0;
            r_data_o <= 32'h0;
            r_led    <= 16'h0;
            r_cmp    <= 32'h0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (breq_i) begin
                        r_addr  <= addr_i;
                        r_data  <= data_i;
                        r_we    <= mem_w;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_is_ram) begin
                        r_state <= RAM_WAIT;
                    end else begin
                        if (!r_we) begin
                            r_data_o <= w_rd_data;
                        end
                        if (w_io_wr && w_sel_led) begin
                            r_led <= r_data[15:0];
                        end
                        if (w_io_wr && w_sel_cmp) begin
                            r_cmp <= r_data;
                        end
                        r_state <= RESP;
                    end
                end
                RAM_WAIT: begin
                    if (!r_we) begin
                        r_data_o <= ram_dout;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Timer: free-running count, cleared on match or CPU write; match latches pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= 32'h0;
            r_pend <= 1'b0;
        end else begin
            if (w_wr_cnt || w_match) begin
                r_cnt <= 32'h0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
            // A match beats a coincident acknowledge; a count write hides the match.
            if (w_match && !w_wr_cnt) begin
                r_pend <= 1'b1;
            end else if (Iack) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign ready_o  = (r_state == RESP);
    assign ram_en   = (r_state == ACCESS) && w_is_ram;
    assign ram_we   = (r_state == ACCESS) && w_is_ram && r_we;
    assign ram_addr = r_addr[RAM_AW+1:2];
    assign ram_din  = r_data;
    assign data_o   = r_data_o;
    assign led_o    = r_led;
    assign Ireq     = r_pend;

endmodule

// File: doc/mio_bus_ctrl.md
MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

Interface
REQ-001 Parameter RAM_AW, default 10: RAM word-address width; RAM window is 4*2^RAM_AW bytes starting at 0x0000_0000.
REQ-002 Parameter IO_BASE, default 32'hF000_0000: base byte address of the I/O register page.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 breq_i  input  1  CPU bus request (MemRead|MemWrite).
REQ-006 mem_w  input  1  CPU write strobe; 1 = write, 0 = read.
REQ-007 addr_i  input  32  CPU byte address.
REQ-008 data_i  input  32  CPU write data.
REQ-009 data_o  output  32  read data returned to CPU.
REQ-010 ready_o  output  1  transfer-complete strobe to CPU (MIO_ready).
REQ-011 ram_en, ram_we  output  1 each  RAM enable / write enable.
REQ-012 ram_addr  output  RAM_AW  RAM word address.
REQ-013 ram_din  output  32  RAM write data.
REQ-014 ram_dout  input  32  RAM read data; synchronous RAM, valid one cycle after ram_en.
REQ-015 sw_i  input  16  switch inputs.
REQ-016 led_o  output  16  LED register.
REQ-017 Ireq  output  1  timer interrupt request to CPU.
REQ-018 Iack  input  1  CPU interrupt acknowledge.

Function
REQ-019 Address map: addr_i[31:2+RAM_AW]==0 -> RAM; IO_BASE+0x0 LED (R/W, bits 15:0); +0x4 switches (RO, zero-extended); +0x8 timer compare (R/W, 32b); +0xC timer count (read returns count, write of any value clears to 0); all other addresses unmapped.
REQ-020 FSM states IDLE, ACCESS, RAM_WAIT, RESP.
REQ-021 IDLE: when breq_i=1 at a rising edge, latch addr_i, data_i, mem_w into internal registers and go to ACCESS; otherwise remain.
REQ-022 ACCESS, RAM target: ram_en=1, ram_we=latched mem_w, ram_addr=latched addr[RAM_AW+1:2], ram_din=latched data; next state RAM_WAIT.
REQ-023 ACCESS, I/O or unmapped target: I/O write takes effect at the end of this cycle; unmapped writes are discarded; next state RESP.
REQ-024 RAM_WAIT: load data_o from ram_dout on reads (data_o unchanged on writes); next state RESP.
REQ-025 I/O and unmapped reads load data_o at the ACCESS->RESP edge; unmapped reads return 32'h0.
REQ-026 RESP: ready_o=1 for exactly this one cycle; next state IDLE unconditionally.
REQ-027 ready_o and ram_en/ram_we are decoded from registered state only; ram_en=ram_we=0 in every state except ACCESS.
REQ-028 Latency from request-sampling edge to ready_o high: RAM 3 cycles, I/O/unmapped 2 cycles.
REQ-029 breq_i, addr_i, data_i, mem_w are ignored outside IDLE; a request still high in the IDLE cycle after RESP starts a new transfer.
REQ-030 Timer: 32-bit count increments by 1 every cycle; when compare!=0 and count==compare, count becomes 0 next cycle and pending is set; compare==0 disables matching (count wraps 0xFFFF_FFFF->0).
REQ-031 CPU write to count clears it and suppresses any match that cycle; CPU write to compare takes effect for comparisons from the next cycle.
REQ-032 Ireq=pending; Iack=1 clears pending; simultaneous match and Iack leaves pending set.

Reset
REQ-033 Reset forces state IDLE, data_o=0, ready_o=0, ram_en=ram_we=0, ram_addr=0, ram_din=0, led_o=0, compare=0, count=0, pending=0 (Ireq=0), immediately and independent of clk.
REQ-034 Reset asserted mid-transfer aborts it: no ready_o pulse, no pending I/O write is applied, RAM write only if its ACCESS edge already occurred.

Verification
REQ-035 Write 0x1234_5678 to 0x0000_0010, then read 0x0000_0010 -> ram_en/ram_we=1, ram_addr=4 in write ACCESS; read gets data_o=0x1234_5678 with ready_o high 3 cycles after request edge, one cycle wide.
REQ-036 Write 0x0000_A5A5 to IO_BASE+0x0, read IO_BASE+0x4 with sw_i=0x00FF -> led_o=0xA5A5 after 2 cycles; read returns 0x0000_00FF.
REQ-037 Read 0x8000_0000 (unmapped) -> data_o=0, ready_o after 2 cycles; write to same -> no state change anywhere.
REQ-038 Compare=5 -> Ireq rises once count reaches 5, count restarts at 0; Iack pulse clears Ireq; Iack coincident with next match -> Ireq stays 1.
REQ-039 Hold breq_i=1 across two back-to-back RAM reads -> two distinct ready_o pulses, separated by one IDLE cycle.
REQ-040 Assert reset during RAM_WAIT of a read -> ready_o never pulses, all outputs at REQ-033 values; next request completes normally.
